wb_slave_decoder: RTL and testbench

WB_SLAVE_DECODER -- requirements
Module: wb_slave_decoder

---
 rtl/wb_slave_decoder_pkg.sv | 42 ++++
 rtl/wb_slave_decoder_if.sv | 41 ++++
 rtl/wb_slave_decoder_addr_match.sv | 38 +++
 rtl/wb_slave_decoder.sv | 166 ++++++++++++++++
 tb/tb_wb_slave_decoder.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_slave_decoder_pkg.sv
// Shared definitions for the Wishbone slave decoder: FSM encoding, default
// timeout and helpers that build the default address map.
package wb_slave_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEFAULT_TIMEOUT = 15;
   localparam int CNT_W           = 8;
   // Widest packed map the helpers can build: 8 slaves of up to 32 address bits.
   localparam int MAX_PACK        = 8 * 32;

   function automatic logic [MAX_PACK-1:0] default_base(input int ns, input int aw);
      logic [MAX_PACK-1:0] r;
      logic [31:0]         v;
      r = '0;
      for (int i = 0; i < ns; i++) begin
         v = 32'(i) << (aw - 3);
         for (int b = 0; b < aw; b++) begin
            r[i*aw + b] = v[b];
         end
      end
      return r;
   endfunction

   function automatic logic [MAX_PACK-1:0] default_mask(input int ns, input int aw);
      logic [MAX_PACK-1:0] r;
      logic [31:0]         v;
      r = '0;
      v = 32'hFFFF_FFFF << (aw - 3);
      for (int i = 0; i < ns; i++) begin
         for (int b = 0; b < aw; b++) begin
            r[i*aw + b] = v[b];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/wb_slave_decoder_if.sv
// Upstream master request/response plus the fan-out to NS downstream slaves.
interface wb_slave_decoder_if #(
   parameter int AW = 12,
   parameter int NS = 4
);
   logic [AW-3:0]    i_wb_adr;
   logic [31:0]      i_wb_dat;
   logic [3:0]       i_wb_sel;
   logic             i_wb_we;
   logic             i_wb_cyc;
   logic             i_wb_stb;
   logic [31:0]      o_wb_rdt;
   logic             o_wb_ack;
   logic             o_wb_err;

   logic [AW-3:0]    o_s_adr;
   logic [31:0]      o_s_dat;
   logic [3:0]       o_s_sel;
   logic             o_s_we;
   logic [NS-1:0]    o_s_cyc;
   logic [NS-1:0]    o_s_stb;
   logic [32*NS-1:0] i_s_rdt;
   logic [NS-1:0]    i_s_ack;
   logic [NS-1:0]    i_s_err;

   // Decoder side.
   modport slave (
      input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
      input  i_s_rdt, i_s_ack, i_s_err,
      output o_wb_rdt, o_wb_ack, o_wb_err,
      output o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc, o_s_stb
   );

   // Environment side: upstream master and the downstream slaves.
   modport master (
      output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
      output i_s_rdt, i_s_ack, i_s_err,
      input  o_wb_rdt, o_wb_ack, o_wb_err,
      input  o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc, o_s_stb
   );
endinterface

// File: rtl/wb_slave_decoder_addr_match.sv
// Combinational address decoder: one-hot match (lowest index wins on overlap)
// plus a flag saying whether any slave claimed the address.
module wb_addr_match
   import wb_slave_decoder_pkg::*;
#(
   parameter int              AW         = 12,
   parameter int              NS         = 4,
   parameter logic [NS*AW-1:0] SLAVE_BASE = (NS*AW)'(default_base(NS, AW)),
   parameter logic [NS*AW-1:0] SLAVE_MASK = (NS*AW)'(default_mask(NS, AW))
) (
   input  logic [AW-3:0] adr,
   output logic [NS-1:0] match,
   output logic          valid
);

   logic [AW-1:0] byte_adr;
   logic [NS-1:0] hit;

   assign byte_adr = {adr, 2'b00};

   for (genvar gi = 0; gi < NS; gi++) begin : g_hit
      assign hit[gi] = ((byte_adr & SLAVE_MASK[gi*AW +: AW]) == SLAVE_BASE[gi*AW +: AW]);
   end

   // Scan downwards so the lowest hitting index is the one left standing.
   always_comb begin
      match = '0;
      for (int i = NS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            match    = '0;
            match[i] = 1'b1;
         end
      end
   end

   assign valid = |hit;

endmodule

// File: rtl/wb_slave_decoder.sv
// Classic Wishbone 1-to-NS slave decoder with registered request fan-out,
// per-transaction timeout and error response for unmapped addresses.
module wb_slave_decoder
   import wb_slave_decoder_pkg::*;
#(
   parameter int              AW         = 12,
   parameter int              NS         = 4,
   parameter logic [NS*AW-1:0] SLAVE_BASE = (NS*AW)'(default_base(NS, AW)),
   parameter logic [NS*AW-1:0] SLAVE_MASK = (NS*AW)'(default_mask(NS, AW)),
   parameter int              TIMEOUT    = DEFAULT_TIMEOUT
) (
   input  logic              i_clk,
   input  logic              i_rst,
   wb_slave_decoder_if.slave bus
);

   state_t           state_reg, state_next;
   logic [AW-3:0]    adr_reg, adr_next;
   logic [31:0]      dat_reg, dat_next;
   logic [3:0]       sel_reg, sel_next;
   logic             we_reg, we_next;
   logic [NS-1:0]    cyc_reg, cyc_next;
   logic [31:0]      rdt_reg, rdt_next;
   logic             ack_reg, ack_next;
   logic             err_reg, err_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] cnt_inc;

   logic [NS-1:0]    match;
   logic             match_valid;
   logic [31:0]      rdt_masked [NS];
   logic [31:0]      sel_rdt;
   logic             sel_ack;
   logic             sel_err;

   wb_addr_match #(
      .AW         (AW),
      .NS         (NS),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_MASK (SLAVE_MASK)
   ) u_match (
      .adr   (bus.i_wb_adr),
      .match (match),
      .valid (match_valid)
   );

   // cyc_reg is one-hot while busy, so masking and OR-ing picks the active slave.
   for (genvar gi = 0; gi < NS; gi++) begin : g_rdt
      assign rdt_masked[gi] = bus.i_s_rdt[32*gi +: 32] & {32{cyc_reg[gi]}};
   end

   always_comb begin
      sel_rdt = '0;
      for (int i = 0; i < NS; i++) begin
         sel_rdt = sel_rdt | rdt_masked[i];
      end
   end

   assign sel_ack = |(bus.i_s_ack & cyc_reg);
   assign sel_err = |(bus.i_s_err & cyc_reg);

   always_comb begin
      state_next = state_reg;
      adr_next   = adr_reg;
      dat_next   = dat_reg;
      sel_next   = sel_reg;
      we_next    = we_reg;
      cyc_next   = cyc_reg;
      rdt_next   = rdt_reg;
      ack_next   = 1'b0;
      err_next   = 1'b0;
      cnt_next   = cnt_reg;
      // cnt_inc counts the strobe cycle in progress, so the error lands TIMEOUT cycles after the request.
      cnt_inc    = cnt_reg + 1'b1;

      case (state_reg)
         IDLE: begin
            if (bus.i_wb_cyc && bus.i_wb_stb) begin
               if (match_valid) begin
                  adr_next   = bus.i_wb_adr;
                  dat_next   = bus.i_wb_dat;
                  sel_next   = bus.i_wb_sel;
                  we_next    = bus.i_wb_we;
                  cyc_next   = match;
                  cnt_next   = '0;
                  state_next = BUSY;
               end else begin
                  err_next   = 1'b1;
                  rdt_next   = '0;
                  state_next = RESP;
               end
            end
         end
         BUSY: begin
            if (!bus.i_wb_cyc) begin
               cyc_next   = '0;
               state_next = IDLE;
            end else if (sel_ack || sel_err) begin
               cyc_next   = '0;
               sel_next   = '0;
               state_next = RESP;
               if (sel_err) begin
                  err_next = 1'b1;
                  rdt_next = '0;
               end else begin
                  ack_next = 1'b1;
                  if (!we_reg) begin
                     rdt_next = sel_rdt;
                  end
               end
            end else if (cnt_inc == CNT_W'(TIMEOUT - 1)) begin
               cyc_next   = '0;
               sel_next   = '0;
               err_next   = 1'b1;
               rdt_next   = '0;
               state_next = RESP;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= IDLE;
         adr_reg   <= '0;
         dat_reg   <= '0;
         sel_reg   <= '0;
         we_reg    <= 1'b0;
         cyc_reg   <= '0;
         rdt_reg   <= '0;
         ack_reg   <= 1'b0;
         err_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         adr_reg   <= adr_next;
         dat_reg   <= dat_next;
         sel_reg   <= sel_next;
         we_reg    <= we_next;
         cyc_reg   <= cyc_next;
         rdt_reg   <= rdt_next;
         ack_reg   <= ack_next;
         err_reg   <= err_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign bus.o_wb_rdt = rdt_reg;
   assign bus.o_wb_ack = ack_reg;
   assign bus.o_wb_err = err_reg;
   assign bus.o_s_adr  = adr_reg;
   assign bus.o_s_dat  = dat_reg;
   assign bus.o_s_sel  = sel_reg;
   assign bus.o_s_we   = we_reg;
   assign bus.o_s_cyc  = cyc_reg;
   assign bus.o_s_stb  = cyc_reg;

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Randomized bench for wb_slave_decoder against a transaction-level timeline model.
module tb_wb_slave_decoder;

   localparam int AW = 12;
   localparam int NS = 4;
   localparam int TO = 15;
   localparam int REGION = 1 << (AW - 3);

   localparam int K_ACK   = 0;
   localparam int K_ERR   = 1;
   localparam int K_BOTH  = 2;
   localparam int K_NONE  = 3;
   localparam int K_ABORT = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_slave_decoder_if #(.AW(AW), .NS(NS)) bus();

   wb_slave_decoder #(
      .AW      (AW),
      .NS      (NS),
      .TIMEOUT (TO)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   int            n_cmp = 0;
   int            n_bad = 0;
   bit            chk_en = 1'b0;
   int            t_rel = 0;
   int            stb_cnt, ack_t, err_t;
   logic [NS-1:0] exp_stb;
   logic          exp_ack, exp_err;
   logic [31:0]   exp_rdt;
   logic [31:0]   model_rdt;
   logic [AW-3:0] exp_adr;
   logic [31:0]   exp_dat;
   logic [3:0]    exp_sel;
   logic          exp_we;
   logic [NS-1:0] guard;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0d: got %h expected %h", name, t_rel, act, exp);
      end
   endtask

   task automatic zero_check(input string tag);
      chk({tag, "_rdt"}, bus.o_wb_rdt, 32'h0);
      chk({tag, "_ack"}, 32'(bus.o_wb_ack), 32'h0);
      chk({tag, "_err"}, 32'(bus.o_wb_err), 32'h0);
      chk({tag, "_adr"}, 32'(bus.o_s_adr), 32'h0);
      chk({tag, "_dat"}, bus.o_s_dat, 32'h0);
      chk({tag, "_sel"}, 32'(bus.o_s_sel), 32'h0);
      chk({tag, "_we"},  32'(bus.o_s_we), 32'h0);
      chk({tag, "_cyc"}, 32'(bus.o_s_cyc), 32'h0);
      chk({tag, "_stb"}, 32'(bus.o_s_stb), 32'h0);
   endtask

   // Default map: contiguous regions of 2^(AW-3) bytes, slave i at region i.
   function automatic int decode(input logic [AW-3:0] a);
      int b;
      b = int'(a) * 4;
      if (b / REGION < NS) return b / REGION;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("s_stb", 32'(bus.o_s_stb), 32'(exp_stb));
         chk("s_cyc", 32'(bus.o_s_cyc), 32'(exp_stb));
         chk("wb_ack", 32'(bus.o_wb_ack), 32'(exp_ack));
         chk("wb_err", 32'(bus.o_wb_err), 32'(exp_err));
         chk("wb_rdt", bus.o_wb_rdt, exp_rdt);
         if (exp_stb != '0) begin
            chk("s_adr", 32'(bus.o_s_adr), 32'(exp_adr));
            chk("s_dat", bus.o_s_dat, exp_dat);
            chk("s_sel", 32'(bus.o_s_sel), 32'(exp_sel));
            chk("s_we", 32'(bus.o_s_we), 32'(exp_we));
         end
         if (bus.o_s_stb != '0) stb_cnt++;
         if (bus.o_wb_ack === 1'b1) ack_t = t_rel;
         if (bus.o_wb_err === 1'b1) err_t = t_rel;
      end
   end

   // Advance one cycle; other slaves chatter randomly, expectations default to quiet.
   task automatic step();
      @(posedge clk);
      #1;
      t_rel++;
      bus.i_s_ack = NS'($urandom) & ~guard;
      bus.i_s_err = NS'($urandom) & ~guard;
      for (int i = 0; i < NS; i++) bus.i_s_rdt[32*i +: 32] = $urandom;
      exp_stb = '0;
      exp_ack = 1'b0;
      exp_err = 1'b0;
      exp_rdt = model_rdt;
   endtask

   task automatic idle(input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         step();
         bus.i_wb_cyc = 1'b0;
         bus.i_wb_stb = 1'b0;
         bus.i_wb_adr = AW'($urandom) >> 2;
         bus.i_wb_dat = $urandom;
      end
   endtask

   task automatic run_txn(input logic [AW-3:0] adr, input logic we, input logic [31:0] dat,
                          input logic [3:0] sel, input int kind, input int n, input logic [31:0] rv);
      int k, lim;
      k = decode(adr);
      guard = '0;
      if (k >= 0) guard[k] = 1'b1;
      stb_cnt = 0;
      ack_t   = -1;
      err_t   = -1;
      $display("txn adr=%h we=%0d dat=%h sel=%h slave=%0d kind=%0d n=%0d", adr, we, dat, sel, k, kind, n);
      step();
      t_rel = 0;
      bus.i_wb_adr = adr;
      bus.i_wb_we  = we;
      bus.i_wb_dat = dat;
      bus.i_wb_sel = sel;
      bus.i_wb_cyc = 1'b1;
      bus.i_wb_stb = 1'b1;
      exp_adr = adr;
      exp_we  = we;
      exp_dat = dat;
      exp_sel = sel;
      if (k < 0) begin
         step();
         exp_err   = 1'b1;
         model_rdt = '0;
         exp_rdt   = '0;
         step();
         bus.i_wb_cyc = 1'b0;
         bus.i_wb_stb = 1'b0;
      end else begin
         lim = (kind == K_NONE) ? TO - 1 : n;
         for (int t = 1; t <= lim; t++) begin
            step();
            exp_stb = guard;
            if (t == n && kind < K_NONE) begin
               bus.i_s_ack[k] = (kind == K_ACK || kind == K_BOTH);
               bus.i_s_err[k] = (kind == K_ERR || kind == K_BOTH);
               bus.i_s_rdt[32*k +: 32] = rv;
            end
            if (t == n && kind == K_ABORT) begin
               bus.i_wb_cyc = 1'b0;
               bus.i_wb_stb = 1'b0;
            end
         end
         step();
         if (kind == K_ACK) begin
            exp_ack = 1'b1;
            if (!we) model_rdt = rv;
         end else if (kind != K_ABORT) begin
            exp_err   = 1'b1;
            model_rdt = '0;
         end
         exp_rdt = model_rdt;
         if (kind != K_ABORT) step();
         bus.i_wb_cyc = 1'b0;
         bus.i_wb_stb = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [AW-3:0] r_adr;
      int            r_kind, r_n;

      rst          = 1'b1;
      model_rdt    = '0;
      guard        = '0;
      bus.i_wb_adr = 10'h100;
      bus.i_wb_dat = 32'hDEAD_BEEF;
      bus.i_wb_sel = 4'hF;
      bus.i_wb_we  = 1'b1;
      bus.i_wb_cyc = 1'b1;
      bus.i_wb_stb = 1'b1;
      bus.i_s_ack  = '1;
      bus.i_s_err  = '0;
      bus.i_s_rdt  = '1;
      #1;
      zero_check("rst0");
      repeat (2) @(posedge clk);
      #1;
      zero_check("rst1");
      bus.i_wb_cyc = 1'b0;
      bus.i_wb_stb = 1'b0;
      #2;
      rst = 1'b0;
      idle(1);
      chk_en = 1'b1;
      idle(2);

      // Read from slave 2, acked on its second strobe cycle.
      run_txn(10'h100, 1'b0, 32'h0, 4'hF, K_ACK, 2, 32'hCAFE_F00D);
      chk("lit_read_rdt", bus.o_wb_rdt, 32'hCAFE_F00D);
      chk("lit_read_stb", 32'(stb_cnt), 32'd2);
      chk("lit_read_ack_t", 32'(ack_t), 32'd3);
      idle(1);

      // Write to slave 0 with immediate ack; read data must not move.
      run_txn(10'h000, 1'b1, 32'h1234_5678, 4'h3, K_ACK, 1, 32'h5555_AAAA);
      chk("lit_write_ack_t", 32'(ack_t), 32'd2);
      chk("lit_write_rdt", bus.o_wb_rdt, 32'hCAFE_F00D);
      idle(1);

      // Unmapped address.
      run_txn(10'h300, 1'b0, 32'h0, 4'hF, K_ACK, 1, 32'h0);
      chk("lit_unmap_err_t", 32'(err_t), 32'd1);
      chk("lit_unmap_stb", 32'(stb_cnt), 32'd0);
      chk("lit_unmap_rdt", bus.o_wb_rdt, 32'h0);
      idle(1);

      // Slave 1 silent -> timeout, then slave 0 completes normally.
      run_txn(10'h080, 1'b0, 32'h0, 4'hF, K_NONE, 1, 32'h0);
      chk("lit_to_stb", 32'(stb_cnt), 32'd14);
      chk("lit_to_err_t", 32'(err_t), 32'd15);
      chk("lit_to_ack_t", 32'(ack_t), 32'hFFFF_FFFF);
      run_txn(10'h010, 1'b0, 32'h0, 4'hF, K_ACK, 1, 32'h0BAD_CAFE);
      chk("lit_after_to_ack_t", 32'(ack_t), 32'd2);
      chk("lit_after_to_rdt", bus.o_wb_rdt, 32'h0BAD_CAFE);
      idle(1);

      // Slave 3 acks and errs together.
      run_txn(10'h180, 1'b0, 32'h0, 4'hF, K_BOTH, 1, 32'h7777_7777);
      chk("lit_both_ack_t", 32'(ack_t), 32'hFFFF_FFFF);
      chk("lit_both_err_t", 32'(err_t), 32'd2);
      idle(1);

      // Master abort during slave 2 wait.
      run_txn(10'h120, 1'b0, 32'h0, 4'hF, K_ABORT, 3, 32'h0);
      chk("lit_abort_stb", 32'(stb_cnt), 32'd3);
      chk("lit_abort_ack_t", 32'(ack_t), 32'hFFFF_FFFF);
      chk("lit_abort_err_t", 32'(err_t), 32'hFFFF_FFFF);
      idle(1);

      // Response on the terminal timeout cycle beats the timeout.
      run_txn(10'h020, 1'b0, 32'h0, 4'hF, K_ACK, TO - 1, 32'h1357_9BDF);
      chk("lit_late_ack_t", 32'(ack_t), 32'd15);
      chk("lit_late_err_t", 32'(err_t), 32'hFFFF_FFFF);
      idle(1);

      // Asynchronous reset while slave 1 is being strobed.
      chk_en = 1'b0;
      guard  = 4'b0010;
      step();
      bus.i_wb_adr = 10'h080;
      bus.i_wb_we  = 1'b0;
      bus.i_wb_cyc = 1'b1;
      bus.i_wb_stb = 1'b1;
      step();
      step();
      chk("pre_rst_stb", 32'(bus.o_s_stb), 32'h2);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      zero_check("async");
      bus.i_wb_cyc = 1'b0;
      bus.i_wb_stb = 1'b0;
      @(posedge clk);
      #3;
      rst       = 1'b0;
      model_rdt = '0;
      guard     = '0;
      idle(1);
      chk_en = 1'b1;
      idle(2);
      run_txn(10'h0A0, 1'b0, 32'h0, 4'hF, K_ACK, 2, 32'h2468_ACE0);
      chk("lit_post_rst_ack_t", 32'(ack_t), 32'd3);

      for (int r = 0; r < 160; r++) begin
         r_kind = $urandom_range(0, 4);
         if (r_kind == K_NONE && $urandom_range(0, 2) != 0) r_kind = K_ACK;
         r_n = (r_kind == K_ABORT) ? $urandom_range(1, TO - 2) : $urandom_range(1, TO - 1);
         if ($urandom_range(0, 1) == 1) r_n = $urandom_range(1, 3);
         r_adr = AW'($urandom) >> 2;
         run_txn(r_adr, 1'($urandom), $urandom, 4'($urandom), r_kind, r_n, $urandom);
         idle($urandom_range(0, 2));
      end

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
